// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings, the command-master FSM state type and the
// write-data lane replication helper.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } cmd_state_e;

  // Right-aligned write data is copied onto every byte lane the size can hit,
  // so the slave finds it on whichever lane the address selects.
  function automatic logic [31:0] replicate_wdata(input logic [2:0] size,
                                                  input logic [31:0] data);
    case (size)
      HSIZE_BYTE:  return {4{data[7:0]}};
      HSIZE_HWORD: return {2{data[15:0]}};
      default:     return data;
    endcase
  endfunction

endpackage

// File: rtl/ahb3lite_cmd_master.sv
// Single-outstanding AHB3-lite initiator: valid/ready command in, SINGLE transfer
// on the bus, valid/ready response out. Optional macro AHB3LITE_CMD_MASTER_ALIGN_CHECK_EN.
module ahb3lite_cmd_master
  import ahb3lite_pkg::*;
#(
  parameter int          HADDR_SIZE = 32,
  parameter int          HDATA_SIZE = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  cmd_state_e            state_q, state_d;
  logic [HDATA_SIZE-1:0] wdata_q, wdata_d;
  logic                  err_flag_q, err_flag_d;
  logic                  cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_d, hwdata_d;
  logic [HADDR_SIZE-1:0] haddr_d;
  logic                  hwrite_d;
  logic [2:0]            hsize_d;
  logic [1:0]            htrans_d;
  logic                  reject;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

`ifdef AHB3LITE_CMD_MASTER_ALIGN_CHECK_EN
  assign reject = (cmd_size > HSIZE_WORD)
               || (cmd_size == HSIZE_HWORD && cmd_addr[0])
               || (cmd_size == HSIZE_WORD  && cmd_addr[1:0] != 2'b00);
`else
  assign reject = (cmd_size > HSIZE_WORD);
`endif

  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    wdata_d     = wdata_q;
    err_flag_d  = err_flag_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    haddr_d     = HADDR;
    hwrite_d    = HWRITE;
    hsize_d     = HSIZE;
    htrans_d    = HTRANS;
    hwdata_d    = HWDATA;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          if (reject) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            wdata_d  = cmd_wdata;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          if (HWRITE) hwdata_d = replicate_wdata(HSIZE, wdata_q);
        end
      end
      ST_DATA: begin
        // The first ERROR cycle has HREADY low; remember it for the final cycle.
        if (!HREADY) begin
          if (HRESP == HRESP_ERROR) err_flag_d = 1'b1;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = HWRITE ? '0 : HRDATA;
          rsp_err_d   = err_flag_q | (HRESP != HRESP_OKAY);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          err_flag_d  = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      wdata_q    <= '0;
      err_flag_q <= 1'b0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= HSIZE_BYTE;
      HTRANS     <= HTRANS_IDLE;
      HWDATA     <= '0;
    end else begin
      state_q    <= state_d;
      wdata_q    <= wdata_d;
      err_flag_q <= err_flag_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_rdata  <= rsp_rdata_d;
      HADDR      <= haddr_d;
      HWRITE     <= hwrite_d;
      HSIZE      <= hsize_d;
      HTRANS     <= htrans_d;
      HWDATA     <= hwdata_d;
    end
  end

endmodule
